// File: rtl/dsp_seq_pkg.sv
// Shared constants and types for the DSP MAC sequencer: slice control codes,
// sequencer states and the per-slot OPMODE tag carried down the pipeline.
package dsp_seq_pkg;

  localparam logic [6:0] OPM_FIRST   = 7'b000_0101;  // Z=0, X=Y=M
  localparam logic [6:0] OPM_ACC     = 7'b010_0101;  // Z=P, X=Y=M
  localparam logic [6:0] OPM_HOLD    = 7'b010_0000;  // Z=P, X=Y=0
  localparam logic [3:0] ALUMODE_ADD = 4'b0000;
  localparam logic [4:0] INMODE_AB2  = 5'b00000;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;
  typedef enum logic [1:0] {NONE, FIRST, ACC} tag_t;

  // slot=1 marks a cycle that owns the ALU (a real tap or a stall bubble);
  // a bubble is slot=1 with tag NONE, so it holds P while still clocking CEP.
  typedef struct packed {
    logic slot;
    tag_t tag;
  } slot_t;

  function automatic logic [6:0] tag_to_opmode(input tag_t t);
    case (t)
      FIRST:   return OPM_FIRST;
      ACC:     return OPM_ACC;
      default: return OPM_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/dsp_seq_delay_line.sv
// Fixed-depth shift register with asynchronous active-low clear.
// DEPTH=0 degenerates to a wire.
module dsp_seq_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_shift
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] stage_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) stage_reg <= '0;
          else        stage_reg <= d;
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) stage_reg <= '0;
          else        stage_reg <= g_stage[gi-1].stage_reg;
        end
      end
    end
    assign q = g_stage[DEPTH-1].stage_reg;
  end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Feeds NTAPS (sample, coeff) pairs per group into one DSP slice and returns the dot product.
// Optional macro DSP_SEQ_SAT_EN: saturate the result to OUT_W signed range and flag res_ovf.
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int NTAPS    = 8,
  parameter int PIPE_LAT = 3,
  parameter int OPM_DLY  = 1,
  parameter int OUT_W    = 32
) (
  input  logic             clk,
  input  logic             RSTN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [29:0]      in_a,
  input  logic [17:0]      in_b,
  output logic [29:0]      dsp_A,
  output logic [17:0]      dsp_B,
  output logic [6:0]       dsp_OPMODE,
  output logic [3:0]       dsp_ALUMODE,
  output logic [4:0]       dsp_INMODE,
  output logic             dsp_CEAB,
  output logic             dsp_CEP,
  input  logic [47:0]      dsp_P,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OUT_W-1:0] res_data,
  output logic             res_ovf
);

  localparam int CNT_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NTAPS - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] tap_cnt_reg, tap_cnt_next;
  logic             in_ready_reg, ceab_reg, cep_reg, last_drv_reg;
  logic [29:0]      a_reg;
  logic [17:0]      b_reg;
  slot_t            drv_slot_reg, drv_slot_next, opm_slot;
  logic             res_valid_reg, res_ovf_reg, res_ovf_next, capture;
  logic [OUT_W-1:0] res_data_reg, res_data_next;
  logic             hs_in, last_tap;

  assign hs_in    = in_valid & in_ready_reg;
  assign last_tap = (tap_cnt_reg == LAST_TAP);

  always_comb begin
    state_next   = state_reg;
    tap_cnt_next = tap_cnt_reg;
    case (state_reg)
      IDLE, ACCUM: begin
        if (hs_in) begin
          if (last_tap) begin
            state_next   = DRAIN;
            tap_cnt_next = '0;
          end else begin
            state_next   = ACCUM;
            tap_cnt_next = tap_cnt_reg + 1'b1;
          end
        end
      end
      DRAIN:   if (capture) state_next = OUT;
      OUT:     if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Only cycles inside a group own an ALU slot; IDLE and DRAIN leave P untouched.
  always_comb begin
    drv_slot_next.slot = hs_in | (state_reg == ACCUM);
    drv_slot_next.tag  = NONE;
    if (hs_in) drv_slot_next.tag = (state_reg == IDLE) ? FIRST : ACC;
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state_reg    <= IDLE;
      tap_cnt_reg  <= '0;
      in_ready_reg <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      ceab_reg     <= 1'b0;
      drv_slot_reg <= '0;
      last_drv_reg <= 1'b0;
      cep_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tap_cnt_reg  <= tap_cnt_next;
      in_ready_reg <= (state_next == IDLE) || (state_next == ACCUM);
      ceab_reg     <= hs_in;
      if (hs_in) begin
        a_reg <= in_a;
        b_reg <= in_b;
      end
      drv_slot_reg <= drv_slot_next;
      last_drv_reg <= hs_in & last_tap;
      cep_reg      <= opm_slot.slot;
    end
  end

  dsp_seq_delay_line #(.DEPTH(OPM_DLY), .WIDTH($bits(slot_t))) u_opm_dly (
    .clk   (clk),
    .rst_n (RSTN),
    .d     (drv_slot_reg),
    .q     (opm_slot)
  );

  // The last tap's drive flag reaches the end exactly when P holds the final sum.
  dsp_seq_delay_line #(.DEPTH(PIPE_LAT), .WIDTH(1)) u_cap_dly (
    .clk   (clk),
    .rst_n (RSTN),
    .d     (last_drv_reg),
    .q     (capture)
  );

`ifdef DSP_SEQ_SAT_EN
  localparam logic signed [47:0] SAT_MAX = (48'sd1 <<< (OUT_W - 1)) - 48'sd1;
  localparam logic signed [47:0] SAT_MIN = -(48'sd1 <<< (OUT_W - 1));

  always_comb begin
    res_data_next = dsp_P[OUT_W-1:0];
    res_ovf_next  = 1'b0;
    if ($signed(dsp_P) > SAT_MAX) begin
      res_data_next = SAT_MAX[OUT_W-1:0];
      res_ovf_next  = 1'b1;
    end else if ($signed(dsp_P) < SAT_MIN) begin
      res_data_next = SAT_MIN[OUT_W-1:0];
      res_ovf_next  = 1'b1;
    end
  end
`else
  logic unused_p_hi;
  assign unused_p_hi   = ^dsp_P;
  assign res_data_next = dsp_P[OUT_W-1:0];
  assign res_ovf_next  = 1'b0;
`endif

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_ovf_reg   <= 1'b0;
    end else if (capture) begin
      res_valid_reg <= 1'b1;
      res_data_reg  <= res_data_next;
      res_ovf_reg   <= res_ovf_next;
    end else if (res_valid_reg && res_ready) begin
      res_valid_reg <= 1'b0;
    end
  end

  assign in_ready    = in_ready_reg;
  assign dsp_A       = a_reg;
  assign dsp_B       = b_reg;
  assign dsp_CEAB    = ceab_reg;
  assign dsp_CEP     = cep_reg;
  assign dsp_OPMODE  = tag_to_opmode(opm_slot.tag);
  assign dsp_ALUMODE = ALUMODE_ADD;
  assign dsp_INMODE  = INMODE_AB2;
  assign res_valid   = res_valid_reg;
  assign res_data    = res_data_reg;
  assign res_ovf     = res_ovf_reg;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer driving a behavioural DSP slice (AREG=BREG=MREG=PREG=OPMODEREG=1).
// Expected results follow DSP_SEQ_SAT_EN the same way the design does.
module tb_dsp_mac_sequencer;

  localparam int OW = 16;

  logic          clk = 1'b0;
  logic          RSTN, in_valid, in_ready, res_valid, res_ready, res_ovf;
  logic [29:0]   in_a, dsp_A;
  logic [17:0]   in_b, dsp_B;
  logic [6:0]    dsp_OPMODE;
  logic [3:0]    dsp_ALUMODE;
  logic [4:0]    dsp_INMODE;
  logic          dsp_CEAB, dsp_CEP;
  logic [47:0]   dsp_P;
  logic [OW-1:0] res_data;

  always #5 clk = ~clk;

  dsp_mac_sequencer #(.NTAPS(4), .PIPE_LAT(3), .OPM_DLY(1), .OUT_W(OW)) dut (
    .clk(clk), .RSTN(RSTN), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .dsp_A(dsp_A), .dsp_B(dsp_B),
    .dsp_OPMODE(dsp_OPMODE), .dsp_ALUMODE(dsp_ALUMODE), .dsp_INMODE(dsp_INMODE),
    .dsp_CEAB(dsp_CEAB), .dsp_CEP(dsp_CEP), .dsp_P(dsp_P),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ovf(res_ovf)
  );

  // Slice model; P starts with junk and is never reset.
  logic signed [24:0] a2 = 25'sd77;
  logic signed [17:0] b2 = 18'sd3;
  logic signed [47:0] m_r = 48'sd0;
  logic signed [47:0] p_r = 48'sh0123_4567_89AB;
  logic [6:0]         opm_r = 7'b010_0000;

  always @(posedge clk) begin
    if (dsp_CEAB) begin
      a2 <= dsp_A[24:0];
      b2 <= dsp_B;
    end
    m_r   <= 48'(a2) * 48'(b2);
    opm_r <= dsp_OPMODE;
    if (dsp_CEP)
      p_r <= ((opm_r[6:4] == 3'b010) ? p_r : 48'sd0) + ((opm_r[3:0] == 4'b0101) ? m_r : 48'sd0);
  end
  assign dsp_P = p_r;

  typedef struct packed {
    logic [OW-1:0] d;
    logic          o;
  } res_t;

  typedef struct packed {
    logic [3:0][29:0] a;
    logic [3:0][17:0] b;
    logic [3:0]       stall;
    logic [OW-1:0]    exp_d;
    logic             exp_o;
  } vec_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   t_acc = -1;
  int   t_rv = -1;
  bit   rv_prev = 1'b0;
  bit   rr_rand = 1'b0;
  res_t exp_q[$];
  vec_t tbl[5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: exact signed dot product, then clip or truncate to OW bits.
  function automatic res_t model(input longint s);
    res_t r;
    r.d = s[OW-1:0];
    r.o = 1'b0;
`ifdef DSP_SEQ_SAT_EN
    if (s > 32767) begin
      r.d = 16'h7FFF;
      r.o = 1'b1;
    end else if (s < -32768) begin
      r.d = 16'h8000;
      r.o = 1'b1;
    end
`endif
    return r;
  endfunction

  function automatic longint product(input logic [29:0] a, input logic [17:0] b);
    logic signed [24:0] as;
    logic signed [17:0] bs;
    as = a[24:0];
    bs = b;
    return longint'(as) * longint'(bs);
  endfunction

  always @(negedge clk) begin
    res_t e;
    cyc++;
    if (RSTN && in_valid && in_ready && t_acc < 0) t_acc = cyc;
    if (RSTN && res_valid && !rv_prev && t_rv < 0) t_rv = cyc;
    rv_prev = res_valid;
    if (RSTN && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL res_unexpected got=0x%0h expected=no result", res_data);
      end else begin
        e = exp_q.pop_front();
        check("res_data", 64'(res_data), 64'(e.d));
        check("res_ovf", 64'(res_ovf), 64'(e.o));
        $display("result data=0x%0h ovf=%0d", res_data, res_ovf);
      end
    end
  end

  always @(posedge clk) if (rr_rand) #1 res_ready = ($urandom_range(0, 3) != 0);

  task automatic send_pair(input logic [29:0] a, input logic [17:0] b);
    int  w;
    bit  hs;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    w = 0;
    do begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      w++;
    end while (!hs && w < 300);
    if (!hs) begin
      n_checks++;
      n_errors++;
      $display("FAIL in_accept got=no accept in %0d cycles expected=accept", w);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input vec_t v);
    for (int i = 0; i < 4; i++) begin
      send_pair(v.a[i], v.b[i]);
      if (i == 1 && v.stall != 0) idle(int'(v.stall));
    end
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_res_ovf", 64'(res_ovf), 64'd0);
    check("rst_dsp_A", 64'(dsp_A), 64'd0);
    check("rst_dsp_B", 64'(dsp_B), 64'd0);
    check("rst_opmode", 64'(dsp_OPMODE), 64'h20);
    check("rst_ceab", 64'(dsp_CEAB), 64'd0);
    check("rst_cep", 64'(dsp_CEP), 64'd0);
    check("alumode", 64'(dsp_ALUMODE), 64'd0);
    check("inmode", 64'(dsp_INMODE), 64'd0);
  endtask

  function automatic vec_t mk(input int a0, input int a1, input int a2v, input int a3,
                              input int b0, input int b1, input int b2v, input int b3,
                              input int st, input logic [OW-1:0] d, input logic o);
    vec_t v;
    v.a[0] = 30'(a0); v.a[1] = 30'(a1); v.a[2] = 30'(a2v); v.a[3] = 30'(a3);
    v.b[0] = 18'(b0); v.b[1] = 18'(b1); v.b[2] = 18'(b2v); v.b[3] = 18'(b3);
    v.stall = 4'(st);
    v.exp_d = d;
    v.exp_o = o;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res_t  r;
    vec_t  v;
    longint sum;
    RSTN = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1 RSTN = 1'b1;

    tbl[0] = mk(1, 2, 3, 4, 1, 2, 3, 4, 0, 16'd30, 1'b0);
    tbl[1] = mk(1, 2, 3, 4, 1, 2, 3, 4, 3, 16'd30, 1'b0);
`ifdef DSP_SEQ_SAT_EN
    tbl[2] = mk(16383, 16383, 16383, 16383, 32767, 32767, 32767, 32767, 0, 16'h7FFF, 1'b1);
`else
    tbl[2] = mk(16383, 16383, 16383, 16383, 32767, 32767, 32767, 32767, 0, 16'h0004, 1'b0);
`endif
    tbl[3] = mk(-5, -5, -5, -5, 7, 7, 7, 7, 0, 16'hFF74, 1'b0);
    tbl[4] = mk(100, 100, 100, 100, -2, -2, -2, -2, 0, 16'hFCE0, 1'b0);

    // Table groups go back-to-back; results must come out in order.
    for (int i = 0; i < 5; i++) begin
      r.d = tbl[i].exp_d;
      r.o = tbl[i].exp_o;
      exp_q.push_back(r);
      $display("group %0d queued expected=0x%0h", i, r.d);
      send_vec(tbl[i]);
    end
    idle(1);
    wait_drain();
    check("first_latency", 64'(t_rv - t_acc), 64'd8);

    // Backpressure: result held 10 cycles while the next pair waits.
    res_ready = 1'b0;
    r.d = 16'd30; r.o = 1'b0;
    exp_q.push_back(r);
    send_vec(tbl[0]);
    in_valid = 1'b1; in_a = 30'd7; in_b = 18'd1;
    for (int w = 0; w < 100 && !res_valid; w++) begin
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_res_valid", 64'(res_valid), 64'd1);
      check("hold_res_data", 64'(res_data), 64'd30);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    res_ready = 1'b1;
    r.d = 16'd28;
    exp_q.push_back(r);
    for (int i = 0; i < 4; i++) send_pair(30'd7, 18'd1);
    idle(1);
    wait_drain();

    // Reset after two taps discards the partial sum.
    send_pair(30'd5, 18'd5);
    send_pair(30'd6, 18'd6);
    in_valid = 1'b0;
    RSTN = 1'b0;
    check_reset_outputs();
    @(posedge clk);
    #1 RSTN = 1'b1;
    exp_q.push_back(model(4));
    for (int i = 0; i < 4; i++) send_pair(30'd1, 18'd1);
    idle(1);
    wait_drain();

    // Random groups with stalls, idle gaps and random result backpressure.
    rr_rand = 1'b1;
    for (int g = 0; g < 25; g++) begin
      sum = 0;
      for (int i = 0; i < 4; i++) begin
        if (g % 2 == 0) begin
          v.a[i] = 30'($urandom);
          v.b[i] = 18'($urandom);
        end else begin
          v.a[i] = 30'(int'($urandom_range(0, 400)) - 200);
          v.b[i] = 18'(int'($urandom_range(0, 400)) - 200);
        end
        sum += product(v.a[i], v.b[i]);
      end
      exp_q.push_back(model(sum));
      $display("random group %0d queued expected=0x%0h", g, model(sum).d);
      for (int i = 0; i < 4; i++) begin
        send_pair(v.a[i], v.b[i]);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 4)));
      end
      if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(1);
    rr_rand = 1'b0;
    @(posedge clk);
    #2 res_ready = 1'b1;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
